// File: rtl/z_branch_unit.sv
// z_branch_unit: program counter and conditional-branch sequencer.
// Picks increment / jump / conditional jump on Zin each cycle, inserts a
// one-cycle flush after every taken branch, and supports halt/restart.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | commands accepted; PC increments, jumps or holds
//   FLUSH | one cycle after a taken jump; fetched instruction is invalid
//   HALT  | PC frozen, only restart (or reset) leaves
module z_branch_unit #(
  parameter int unsigned          WIDTH      = 12,
  parameter logic [WIDTH-1:0]     RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             Zin,
  input  logic             incEn,
  input  logic             jmpEn,
  input  logic             jmpZEn,
  input  logic             jmpNZEn,
  input  logic [WIDTH-1:0] jmpAddr,
  input  logic             stall,
  input  logic             haltEn,
  input  logic             restart,
  output logic [WIDTH-1:0] pcOut,
  output logic             branchTaken,
  output logic             flush,
  output logic             halted
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic             taken;
  logic             branch_taken_q;
  logic             flush_q;
  logic             halted_q;

  // All-ones naturally wraps to zero at WIDTH bits.
  assign pc_inc = pc + 1'b1;

  // Next-state / next-PC decode; command priority is encoded by the if-chain.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    taken      = 1'b0;
    case (state)
      RUN: begin
        if (!stall) begin
          if (haltEn) begin
            next_state = HALT;
          end else if (jmpEn) begin
            taken = 1'b1;
          end else if (jmpZEn) begin
            // An untaken conditional still advances the PC.
            if (Zin) taken = 1'b1;
            else     pc_next = pc_inc;
          end else if (jmpNZEn) begin
            if (!Zin) taken = 1'b1;
            else      pc_next = pc_inc;
          end else if (incEn) begin
            pc_next = pc_inc;
          end
          if (taken) begin
            pc_next    = jmpAddr;
            next_state = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Commands issued during the flush slot are dropped on purpose.
        if (!stall) next_state = RUN;
      end
      HALT: begin
        if (!stall && restart) begin
          next_state = RUN;
          pc_next    = RESET_ADDR;
        end
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // State, PC and registered status outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state          <= RUN;
      pc             <= RESET_ADDR;
      branch_taken_q <= 1'b0;
      flush_q        <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state          <= next_state;
      pc             <= pc_next;
      branch_taken_q <= taken;
      flush_q        <= (next_state == FLUSH);
      halted_q       <= (next_state == HALT);
    end
  end

  assign pcOut       = pc;
  assign branchTaken = branch_taken_q;
  assign flush       = flush_q;
  assign halted      = halted_q;

  // A taken jump always lands in FLUSH, so two pulses in a row are impossible.
  a_bt_single : assert property (@(posedge clk) disable iff (!rstN)
    branchTaken |=> !branchTaken);

  // Flush and halt are mutually exclusive states.
  a_excl : assert property (@(posedge clk) disable iff (!rstN)
    !(flush && halted));

endmodule

// File: tb/tb_z_branch_unit.sv
// Self-checking bench for z_branch_unit: directed walk through the main
// scenarios followed by randomized commands, all compared against a
// behavioural model of the PC/branch rules.
module tb_z_branch_unit;

  localparam int WIDTH      = 12;
  localparam int RESET_ADDR = 0;
  localparam int PC_MOD     = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rstN;
  logic             Zin;
  logic             incEn;
  logic             jmpEn;
  logic             jmpZEn;
  logic             jmpNZEn;
  logic [WIDTH-1:0] jmpAddr;
  logic             stall;
  logic             haltEn;
  logic             restart;
  logic [WIDTH-1:0] pcOut;
  logic             branchTaken;
  logic             flush;
  logic             halted;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 = running, 1 = flushing, 2 = halted.
  int m_pc;
  int m_mode;
  int m_bt;

  z_branch_unit #(
    .WIDTH      (WIDTH),
    .RESET_ADDR (12'(RESET_ADDR))
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .Zin         (Zin),
    .incEn       (incEn),
    .jmpEn       (jmpEn),
    .jmpZEn      (jmpZEn),
    .jmpNZEn     (jmpNZEn),
    .jmpAddr     (jmpAddr),
    .stall       (stall),
    .haltEn      (haltEn),
    .restart     (restart),
    .pcOut       (pcOut),
    .branchTaken (branchTaken),
    .flush       (flush),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_cmds();
    Zin = 1'b0; incEn = 1'b0; jmpEn = 1'b0; jmpZEn = 1'b0; jmpNZEn = 1'b0;
    jmpAddr = '0; stall = 1'b0; haltEn = 1'b0; restart = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = RESET_ADDR; m_mode = 0; m_bt = 0;
  endtask

  task automatic model_edge();
    int bt;
    bt = 0;
    case (m_mode)
      0: begin
        if (stall) begin
        end else if (haltEn) begin
          m_mode = 2;
        end else if (jmpEn || (jmpZEn && Zin) || (!jmpZEn && jmpNZEn && !Zin)) begin
          m_pc = int'(jmpAddr); m_mode = 1; bt = 1;
        end else if (jmpZEn || jmpNZEn || incEn) begin
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end
      1: if (!stall) m_mode = 0;
      default: if (!stall && restart) begin m_pc = RESET_ADDR; m_mode = 0; end
    endcase
    m_bt = bt;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".pc"},     int'(pcOut),       m_pc);
    chk({tag, ".bt"},     int'(branchTaken), m_bt);
    chk({tag, ".flush"},  int'(flush),       (m_mode == 1) ? 1 : 0);
    chk({tag, ".halted"}, int'(halted),      (m_mode == 2) ? 1 : 0);
  endtask

  // One clock: inputs are already set; advance model, sample just after edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  // Pull reset low between edges and confirm the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    rstN = 1'b0;
    #1;
    model_reset();
    check_outs(tag);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    clear_cmds();
    rstN = 1'b0;
    model_reset();
    #12;
    check_outs("reset");
    @(negedge clk);
    rstN = 1'b1;

    incEn = 1'b1;
    for (int i = 1; i <= 5; i++) cycle("inc");
    chk("inc_to_5", int'(pcOut), 5);
    async_reset("async_rst");
    chk("async_rst_pc", int'(pcOut), 0);

    // Back to PC=5, then a taken jz.
    repeat (5) cycle("inc2");
    clear_cmds();
    Zin = 1'b1; jmpZEn = 1'b1; jmpAddr = 12'h123;
    cycle("jz_taken");
    chk("jz_taken_pc", int'(pcOut), 'h123);
    chk("jz_taken_bt", int'(branchTaken), 1);
    clear_cmds();
    cycle("jz_flush_end");
    chk("jz_bt_once", int'(branchTaken), 0);

    jmpEn = 1'b1; jmpAddr = 12'd5;
    cycle("jmp_to_5");
    clear_cmds();
    cycle("flush_to_5");
    Zin = 1'b0; jmpZEn = 1'b1; jmpAddr = 12'h123;
    cycle("jz_untaken");
    chk("jz_untaken_pc", int'(pcOut), 6);
    chk("jz_untaken_flush", int'(flush), 0);

    clear_cmds();
    Zin = 1'b0; jmpNZEn = 1'b1; jmpAddr = 12'h0FF;
    cycle("jnz_taken");
    chk("jnz_taken_pc", int'(pcOut), 'h0FF);
    clear_cmds();
    cycle("jnz_flush_end");
    Zin = 1'b1; jmpNZEn = 1'b1; jmpAddr = 12'h777;
    cycle("jnz_untaken");
    chk("jnz_untaken_pc", int'(pcOut), 'h100);
    clear_cmds();
    Zin = 1'b0; jmpEn = 1'b1; jmpZEn = 1'b1; jmpAddr = 12'h2AA;
    cycle("jmp_prio");
    chk("jmp_prio_pc", int'(pcOut), 'h2AA);
    clear_cmds();
    cycle("jmp_prio_end");

    jmpEn = 1'b1; jmpAddr = 12'hFFF;
    cycle("to_fff");
    clear_cmds();
    cycle("to_fff_end");
    incEn = 1'b1;
    cycle("wrap");
    chk("wrap_pc", int'(pcOut), 0);
    clear_cmds();
    stall = 1'b1; jmpEn = 1'b1; jmpAddr = 12'h555;
    cycle("stall_jmp");
    chk("stall_jmp_pc", int'(pcOut), 0);
    chk("stall_jmp_flush", int'(flush), 0);

    clear_cmds();
    jmpEn = 1'b1; jmpAddr = 12'h321;
    cycle("jmp_a");
    jmpAddr = 12'h456;
    cycle("jmp_in_flush");
    chk("jmp_in_flush_pc", int'(pcOut), 'h321);
    clear_cmds();
    cycle("after_flush");
    chk("after_flush_pc", int'(pcOut), 'h321);

    haltEn = 1'b1;
    cycle("halt");
    chk("halt_flag", int'(halted), 1);
    clear_cmds();
    incEn = 1'b1; jmpEn = 1'b1; jmpAddr = 12'h111;
    repeat (4) cycle("halt_ignore");
    chk("halt_hold_pc", int'(pcOut), 'h321);
    clear_cmds();
    restart = 1'b1; stall = 1'b1;
    cycle("restart_stalled");
    stall = 1'b0;
    cycle("restart");
    chk("restart_pc", int'(pcOut), RESET_ADDR);
    chk("restart_halted", int'(halted), 0);
    clear_cmds();

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      Zin     = 1'($urandom_range(0, 1));
      stall   = ($urandom_range(0, 9) == 0);
      haltEn  = ($urandom_range(0, 24) == 0);
      jmpEn   = ($urandom_range(0, 5) == 0);
      jmpZEn  = ($urandom_range(0, 4) == 0);
      jmpNZEn = ($urandom_range(0, 4) == 0);
      incEn   = ($urandom_range(0, 1) == 0);
      restart = ($urandom_range(0, 3) == 0);
      jmpAddr = 12'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      else cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z_branch_unit.md
# z_branch_unit

Program-counter and conditional-branch unit for each processor core. It consumes the registered zero flag produced by the core's Z register and decides, each cycle, whether the program counter increments, jumps unconditionally, or jumps conditionally on Z / not-Z. It sits between the control unit (which issues increment and jump commands) and instruction memory (which is addressed by `pcOut`). A taken branch triggers a one-cycle flush so the control unit discards the already-fetched instruction.

## Interface
- `WIDTH`, 12, program-counter / jump-address width in bits
- `RESET_ADDR`, 0, value loaded into the PC on reset and on `restart`
- `clk`  in  1  core clock; all state updates on the rising edge
- `rstN`  in  1  asynchronous, active-low reset
- `Zin`  in  1  zero flag from the Z register (already registered upstream)
- `incEn`  in  1  advance PC by 1
- `jmpEn`  in  1  unconditional jump to `jmpAddr`
- `jmpZEn`  in  1  jump to `jmpAddr` if `Zin`=1
- `jmpNZEn`  in  1  jump to `jmpAddr` if `Zin`=0
- `jmpAddr`  in  WIDTH  branch target
- `stall`  in  1  freeze PC and state
- `haltEn`  in  1  enter HALT
- `restart`  in  1  leave HALT; PC reloads `RESET_ADDR`
- `pcOut`  out  WIDTH  current program counter
- `branchTaken`  out  1  one-cycle pulse: a jump was taken at the previous edge
- `flush`  out  1  high while in FLUSH; the fetched instruction is invalid
- `halted`  out  1  high in HALT

## Operation
- States: RUN, FLUSH, HALT. Reset: state=RUN, `pcOut`=`RESET_ADDR`, `branchTaken`=0, `flush`=0, `halted`=0.
- Command priority within RUN, highest first: `stall` > `haltEn` > `jmpEn` > `jmpZEn` > `jmpNZEn` > `incEn`. Only the highest-priority asserted command acts.
- `stall`=1: PC, state, and outputs hold, except `branchTaken`, which clears to 0.
- `haltEn` (RUN): go to HALT, PC holds.
- Taken jump: an unconditional jump, `jmpZEn` with `Zin`=1, or `jmpNZEn` with `Zin`=0.
  - On a taken jump, PC loads `jmpAddr`, `branchTaken` pulses for 1 cycle, and state goes to FLUSH.
- Untaken conditional jump: behaves as `incEn` (PC+1), with no flush and no pulse, whether or not `incEn` is asserted.
- `incEn` only: PC = PC+1 modulo 2^WIDTH, so all-ones wraps to 0.
- No command asserted: PC holds.
- FLUSH: lasts exactly one cycle and ignores every command except `stall` and reset. `stall` extends FLUSH. PC holds at the target. Next state is RUN.
- HALT: PC holds and all commands are ignored. `restart` loads `RESET_ADDR` and returns to RUN. `stall` has priority over `restart`.
- `Zin` is sampled in the same cycle as the conditional command. There is no internal copy of Z.

## Timing
- All outputs are registered. A command in cycle n takes effect on `pcOut` after edge n+1.
- Jump latency: target is visible one cycle after the command; `flush`=1 during that same cycle; the next command is accepted one cycle later.
- `branchTaken` and `flush` assert in the same cycle. `branchTaken` is never high for 2 consecutive cycles.
- Asserting `rstN`=0 at any time, including mid-FLUSH or in HALT, immediately forces the reset values without waiting for `clk`. Release is synchronous to the next edge.
- Back-to-back jumps: a jump issued during FLUSH is dropped. The control unit must reissue it.

## Test plan
- Reset, then 5 cycles of `incEn`: `pcOut` goes 0,1,2,3,4,5. Then hold `rstN`=0 mid-sequence: `pcOut`=0 asynchronously.
- `Zin`=1, `jmpZEn`, `jmpAddr`=0x123 from PC=5: next `pcOut`=0x123 with `branchTaken`=`flush`=1 for one cycle. Repeat with `Zin`=0: `pcOut`=6 with no flush.
- `jmpNZEn` with `Zin`=0 to 0x0FF: taken. `jmpNZEn` with `Zin`=1: PC+1. `jmpEn` and `jmpZEn` together with `Zin`=0: the unconditional jump wins.
- PC=0xFFF, `incEn`: `pcOut`=0x000. `stall` together with `jmpEn`: PC unchanged, no flush.
- Jump taken and `jmpEn` asserted during FLUSH: the second jump is ignored, and PC = first target until the next command.
- `haltEn`: `halted`=1, and `incEn`/`jmpEn` are ignored for 4 cycles. `restart`: `pcOut`=`RESET_ADDR`, `halted`=0, state RUN.
